// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C register-file slave.
//   state_t : byte-level FSM states
//   cond_t  : bus condition reported by the condition detector
//   I2C_READ / I2C_WRITE : values of the R/W bit in the address byte
package i2c_slave_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 4;   // counts 0..8 bits of a byte

  localparam logic I2C_READ  = 1'b1;
  localparam logic I2C_WRITE = 1'b0;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR,
    WR_ACK,
    RD,
    RD_ACK,
    WAIT_STOP
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    START,
    STOP
  } cond_t;

endpackage

// File: rtl/i2c_cond_det.sv
// Bus front end: 2-flop synchronizers for SCL/SDA plus SCL edge and
// START/STOP detection on the synchronized values.
//   clk_i, rst_ni : system clock, async active-low reset
//   scl_i, sda_i  : raw bus lines
//   sda_s         : synchronized SDA (registered)
//   scl_rise_c    : synchronized SCL rising edge (combinational)
//   scl_fall_c    : synchronized SCL falling edge (combinational)
//   cond_c        : START / STOP / NONE for this cycle (combinational)
module i2c_cond_det
  import i2c_slave_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  scl_i,
  input  logic  sda_i,
  output logic  sda_s,
  output logic  scl_rise_c,
  output logic  scl_fall_c,
  output cond_t cond_c
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       sda_prev_q;
  logic       scl_s;

  // Synchronizer chains plus one history flop each for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];

  assign scl_rise_c =  scl_s & ~scl_prev_q;
  assign scl_fall_c = ~scl_s &  scl_prev_q;

  // SDA may only move as a condition while SCL stays high across both samples.
  always_comb begin
    cond_c = NONE;
    if (scl_s && scl_prev_q) begin
      if (sda_prev_q && !sda_s) begin
        cond_c = START;
      end else if (!sda_prev_q && sda_s) begin
        cond_c = STOP;
      end
    end
  end

endmodule

// File: rtl/i2c_slave_resp.sv
// I2C slave exposing MEM_DEPTH 8-bit registers behind an auto-incrementing
// pointer. Write: addr/W, pointer byte, data bytes. Read: addr/R streams
// mem[ptr], mem[ptr+1], ... until the master NACKs.
//   clk_i, rst_ni       : system clock, async active-low reset
//   scl_i, sda_i        : bus inputs (wired-AND)
//   sda_o, scl_o        : open-drain drives (0 = pull low, 1 = release)
//   busy_o              : START seen, STOP not yet seen
//   wr_stb_o            : one-cycle pulse per register written
//   wr_addr_o/wr_data_o : index and data of the last write
// Build option: define I2C_SLAVE_CLK_STRETCH_EN to hold SCL low for
// STRETCH_CYCLES clocks after every ACK slot; otherwise scl_o is tied high.
module i2c_slave_resp
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR     = 7'h22,
  parameter int unsigned MEM_DEPTH      = 16,
  parameter int unsigned STRETCH_CYCLES = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         scl_i,
  input  logic                         sda_i,
  output logic                         sda_o,
  output logic                         scl_o,
  output logic                         busy_o,
  output logic                         wr_stb_o,
  output logic [$clog2(MEM_DEPTH)-1:0] wr_addr_o,
  output logic [7:0]                   wr_data_o
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  // Elaboration-time parameter sanity.
  if (MEM_DEPTH < 2 || MEM_DEPTH > 256 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("MEM_DEPTH must be a power of two in 2..256");
  end
  if (STRETCH_CYCLES == 0) begin : g_bad_stretch
    $error("STRETCH_CYCLES must be at least 1");
  end

  state_t                state_q, state_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]     shift_q, shift_d;
  logic [AW-1:0]         ptr_q, ptr_d;
  logic                  nack_q, nack_d;
  logic                  sda_d;
  logic                  busy_d;
  logic                  wr_stb_d;
  logic [AW-1:0]         wr_addr_d;
  logic [BYTE_W-1:0]     wr_data_d;
  logic                  mem_we_c;
  logic [BYTE_W-1:0]     rx_byte_c;
  logic [BYTE_W-1:0]     rd_byte_c;
  logic [BYTE_W-1:0]     mem_q [MEM_DEPTH];

  logic                  sda_s;
  logic                  scl_rise_c;
  logic                  scl_fall_c;
  cond_t                 cond_c;

  i2c_cond_det u_cond_det (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_s      (sda_s),
    .scl_rise_c (scl_rise_c),
    .scl_fall_c (scl_fall_c),
    .cond_c     (cond_c)
  );

  // Byte as it stands once the bit being sampled now is shifted in.
  assign rx_byte_c = {shift_q[BYTE_W-2:0], sda_s};
  assign rd_byte_c = mem_q[ptr_q];

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      nack_q    <= 1'b1;
      sda_o     <= 1'b1;
      busy_o    <= 1'b0;
      wr_stb_o  <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      nack_q    <= nack_d;
      sda_o     <= sda_d;
      busy_o    <= busy_d;
      wr_stb_o  <= wr_stb_d;
      wr_addr_o <= wr_addr_d;
      wr_data_o <= wr_data_d;
    end
  end

  // Register file; cleared by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we_c) begin
      mem_q[ptr_q] <= rx_byte_c;
    end
  end

  // Next-state logic. Receive states shift on SCL rise; the fall after the
  // 8th bit opens the ACK slot and the next fall closes it, so sda_o only
  // ever moves right after a falling SCL edge.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    nack_d    = nack_q;
    sda_d     = sda_o;
    busy_d    = busy_o;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_o;
    wr_data_d = wr_data_o;
    mem_we_c  = 1'b0;

    if (cond_c == START) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_d     = 1'b1;
      busy_d    = 1'b1;
    end else if (cond_c == STOP) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_d     = 1'b1;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, WAIT_STOP: begin
          sda_d = 1'b1;
        end

        ADDR: begin
          if (scl_rise_c && bit_cnt_q != BIT_CNT_W'(8)) begin
            shift_d   = rx_byte_c;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end else if (scl_fall_c && bit_cnt_q == BIT_CNT_W'(8)) begin
            bit_cnt_d = '0;
            if (shift_q[7:1] == SLAVE_ADDR) begin
              state_d = ADDR_ACK;
              sda_d   = 1'b0;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end

        PTR: begin
          if (scl_rise_c && bit_cnt_q != BIT_CNT_W'(8)) begin
            shift_d   = rx_byte_c;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == BIT_CNT_W'(7)) begin
              ptr_d = rx_byte_c[AW-1:0];
            end
          end else if (scl_fall_c && bit_cnt_q == BIT_CNT_W'(8)) begin
            bit_cnt_d = '0;
            state_d   = PTR_ACK;
            sda_d     = 1'b0;
          end
        end

        WR: begin
          if (scl_rise_c && bit_cnt_q != BIT_CNT_W'(8)) begin
            shift_d   = rx_byte_c;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == BIT_CNT_W'(7)) begin
              mem_we_c  = 1'b1;
              wr_stb_d  = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = rx_byte_c;
              ptr_d     = ptr_q + AW'(1);
            end
          end else if (scl_fall_c && bit_cnt_q == BIT_CNT_W'(8)) begin
            bit_cnt_d = '0;
            state_d   = WR_ACK;
            sda_d     = 1'b0;
          end
        end

        ADDR_ACK: begin
          if (scl_fall_c) begin
            bit_cnt_d = '0;
            unique case (shift_q[0])
              I2C_WRITE: begin
                state_d = PTR;
                sda_d   = 1'b1;
              end
              I2C_READ: begin
                state_d = RD;
                shift_d = rd_byte_c;
                sda_d   = rd_byte_c[7];
              end
            endcase
          end
        end

        PTR_ACK, WR_ACK: begin
          if (scl_fall_c) begin
            bit_cnt_d = '0;
            state_d   = WR;
            sda_d     = 1'b1;
          end
        end

        RD: begin
          // Bit 7 went out on entry; each fall presents the next bit.
          if (scl_fall_c) begin
            if (bit_cnt_q == BIT_CNT_W'(7)) begin
              bit_cnt_d = '0;
              state_d   = RD_ACK;
              sda_d     = 1'b1;
              ptr_d     = ptr_q + AW'(1);
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
              shift_d   = {shift_q[BYTE_W-2:0], 1'b0};
              sda_d     = shift_q[BYTE_W-2];
            end
          end
        end

        RD_ACK: begin
          if (scl_rise_c) begin
            nack_d = sda_s;
          end else if (scl_fall_c) begin
            bit_cnt_d = '0;
            if (!nack_q) begin
              state_d = RD;
              shift_d = rd_byte_c;
              sda_d   = rd_byte_c[7];
            end else begin
              state_d = WAIT_STOP;
              sda_d   = 1'b1;
            end
          end
        end

        default: begin
          state_d = IDLE;
          sda_d   = 1'b1;
        end
      endcase
    end
  end

`ifdef I2C_SLAVE_CLK_STRETCH_EN
  localparam int unsigned SCW = $clog2(STRETCH_CYCLES + 1);

  logic           ack_end_c;
  logic           scl_q;
  logic [SCW-1:0] stretch_cnt_q;

  // Falling SCL that closes any ACK slot, slave's or master's.
  assign ack_end_c = scl_fall_c && (cond_c == NONE) &&
                     (state_q == ADDR_ACK || state_q == PTR_ACK ||
                      state_q == WR_ACK   || state_q == RD_ACK);

  // Hold SCL low for exactly STRETCH_CYCLES clocks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_q         <= 1'b1;
      stretch_cnt_q <= '0;
    end else if (ack_end_c) begin
      scl_q         <= 1'b0;
      stretch_cnt_q <= SCW'(STRETCH_CYCLES - 1);
    end else if (!scl_q) begin
      if (stretch_cnt_q == '0) begin
        scl_q <= 1'b1;
      end else begin
        stretch_cnt_q <= stretch_cnt_q - SCW'(1);
      end
    end
  end

  assign scl_o = scl_q;
`else
  assign scl_o = 1'b1;
`endif

endmodule

// File: tb/tb_i2c_slave_resp.sv
// Bench for i2c_slave_resp: a bit-banged I2C master with scoreboarded
// ACK/read-data checks and a write-strobe monitor.
module tb_i2c_slave_resp;

  localparam int unsigned Q = 10;  // clk cycles per quarter SCL period

  typedef struct packed {
    logic [7:0] tag;
    logic [7:0] val;
  } bus_t;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk;
  logic       rst_n;
  logic       scl_m;
  logic       sda_m;
  logic       scl_bus;
  logic       sda_bus;
  logic       sda_o;
  logic       scl_o;
  logic       busy;
  logic       wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  int errors = 0;
  int checks = 0;
  int low_run = 0;
  int stretches = 0;

  bus_t exp_bus_q[$];
  bus_t obs_q[$];
  wr_t  exp_wr_q[$];
  bus_t bus_obs;
  bus_t bus_exp;
  wr_t  wr_exp;

  assign scl_bus = scl_m & scl_o;
  assign sda_bus = sda_m & sda_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  i2c_slave_resp dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .scl_i     (scl_bus),
    .sda_i     (sda_bus),
    .sda_o     (sda_o),
    .scl_o     (scl_o),
    .busy_o    (busy),
    .wr_stb_o  (wr_stb),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Release SCL and wait (bounded) for the bus to actually go high.
  task automatic scl_up();
    int n = 0;
    scl_m = 1'b1;
    while (!scl_bus && n < 1000) begin
      wait_clks(1);
      n++;
    end
    chk("scl_release", 32'(scl_bus), 32'd1);
  endtask

  task automatic clock_bit(input logic b, output logic r);
    sda_m = b;
    wait_clks(Q);
    scl_up();
    wait_clks(Q);
    r = sda_bus;
    wait_clks(Q);
    scl_m = 1'b0;
    wait_clks(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_clks(Q);
    scl_up();
    wait_clks(Q);
    sda_m = 1'b0;
    wait_clks(Q);
    scl_m = 1'b0;
    wait_clks(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_clks(Q);
    scl_up();
    wait_clks(Q);
    sda_m = 1'b1;
    wait_clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input logic exp_ack);
    logic r;
    exp_bus_q.push_back(bus_t'({8'h41, 7'd0, exp_ack}));
    for (int i = 7; i >= 0; i--) clock_bit(d[i], r);
    clock_bit(1'b1, r);
    obs_q.push_back(bus_t'({8'h41, 7'd0, r}));
  endtask

  task automatic read_byte(input logic mack, input logic [7:0] exp);
    logic [7:0] d;
    logic       r;
    exp_bus_q.push_back(bus_t'({8'h52, exp}));
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, r);
      d[i] = r;
    end
    clock_bit(mack, r);
    obs_q.push_back(bus_t'({8'h52, d}));
  endtask

  // Bus scoreboard: ACK bits and read bytes seen by the master.
  always @(negedge clk) begin
    while (obs_q.size() != 0) begin
      bus_obs = obs_q.pop_front();
      if (exp_bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus_unexp: got 0x%0h with no expected entry", bus_obs.val);
      end else begin
        bus_exp = exp_bus_q.pop_front();
        chk((bus_exp.tag == 8'h41) ? "bus_ack" : "bus_rd_data", 32'(bus_obs), 32'(bus_exp));
      end
    end
  end

  // Write-strobe monitor.
  always @(negedge clk) begin
    if (rst_n && wr_stb) begin
      if (exp_wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexp: got addr %0d data 0x%0h, expected no write", wr_addr, wr_data);
      end else begin
        wr_exp = exp_wr_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(wr_exp.addr));
        chk("wr_data", 32'(wr_data), 32'(wr_exp.data));
      end
    end
  end

  // SCL stretch monitor.
  always @(negedge clk) begin
    if (!scl_o) begin
      low_run++;
    end else if (low_run != 0) begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      chk("stretch_len", 32'(low_run), 32'd8);
`endif
      stretches++;
      low_run = 0;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sda_o"},   32'(sda_o),   32'd1);
    chk({tag, "_scl_o"},   32'(scl_o),   32'd1);
    chk({tag, "_busy"},    32'(busy),    32'd0);
    chk({tag, "_wr_stb"},  32'(wr_stb),  32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
  endtask

  initial begin
    logic r;
    rst_n = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_clks(5);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    wait_clks(5);

    // Write pointer 3, then 0xA5, 0x5A.
    i2c_start();
    chk("busy_after_start", 32'(busy), 32'd1);
    write_byte(8'h44, 1'b0);
    write_byte(8'h03, 1'b0);
    exp_wr_q.push_back(wr_t'({4'd3, 8'hA5}));
    write_byte(8'hA5, 1'b0);
    exp_wr_q.push_back(wr_t'({4'd4, 8'h5A}));
    write_byte(8'h5A, 1'b0);
    i2c_stop();
    chk("busy_after_stop", 32'(busy), 32'd0);

    // Pointer 3, repeated START, read two bytes (ACK then NACK).
    i2c_start();
    write_byte(8'h44, 1'b0);
    write_byte(8'h03, 1'b0);
    i2c_start();
    write_byte(8'h45, 1'b0);
    read_byte(1'b0, 8'hA5);
    read_byte(1'b1, 8'h5A);
    chk("nack_sda_released", 32'(sda_o), 32'd1);
    i2c_stop();

    // Wrong address: no ACK, no writes.
    i2c_start();
    write_byte(8'h46, 1'b1);
    write_byte(8'h03, 1'b1);
    write_byte(8'h77, 1'b1);
    chk("busy_mismatch", 32'(busy), 32'd1);
    i2c_stop();

    // Pointer wrap: 15 -> 0.
    i2c_start();
    write_byte(8'h44, 1'b0);
    write_byte(8'h0F, 1'b0);
    exp_wr_q.push_back(wr_t'({4'd15, 8'h11}));
    write_byte(8'h11, 1'b0);
    exp_wr_q.push_back(wr_t'({4'd0, 8'h22}));
    write_byte(8'h22, 1'b0);
    i2c_stop();
    i2c_start();
    write_byte(8'h44, 1'b0);
    write_byte(8'h0F, 1'b0);
    i2c_start();
    write_byte(8'h45, 1'b0);
    read_byte(1'b0, 8'h11);
    read_byte(1'b1, 8'h22);
    i2c_stop();

    // Reset during the 4th bit of a read of mem[3] = 0xA5 (bit is 0).
    i2c_start();
    write_byte(8'h44, 1'b0);
    write_byte(8'h03, 1'b0);
    i2c_start();
    write_byte(8'h45, 1'b0);
    for (int i = 0; i < 3; i++) clock_bit(1'b1, r);
    sda_m = 1'b1;
    wait_clks(Q);
    scl_up();
    wait_clks(Q);
    chk("rd_bit4_driven", 32'(sda_o), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    wait_clks(5);
    rst_n = 1'b1;
    wait_clks(2);
    chk("busy_after_rst", 32'(busy), 32'd0);
    wait_clks(Q);
    scl_m = 1'b0;
    wait_clks(Q);
    write_byte(8'h44, 1'b1);  // no START yet: must be ignored
    i2c_stop();
    i2c_start();
    write_byte(8'h44, 1'b0);
    write_byte(8'h00, 1'b0);
    i2c_start();
    write_byte(8'h45, 1'b0);
    read_byte(1'b1, 8'h00);
    i2c_stop();

    wait_clks(20);
    chk("exp_wr_left", 32'(exp_wr_q.size()), 32'd0);
    chk("exp_bus_left", 32'(exp_bus_q.size()), 32'd0);
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    chk("stretch_seen", 32'(stretches > 0), 32'd1);
`else
    chk("scl_o_never_low", 32'(stretches + low_run), 32'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    repeat (300000) @(posedge clk);
    $display("FAIL watchdog: run still active after 300000 cycles, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2c_slave_resp.md
I2C_SLAVE_RESP -- requirements
Module: i2c_slave_resp

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h22: 7-bit I2C address the block responds to.
REQ-002 SHALL have parameter MEM_DEPTH, default 16: number of 8-bit registers, power of two, 2..256.
REQ-003 SHALL have parameter STRETCH_CYCLES, default 8: clk_i cycles SCL is held low after each byte's ACK slot (used only when stretching is compiled in).
REQ-004 clk_i  in  1  system clock; the block SHALL be clocked on its rising edge.
REQ-005 rst_ni  in  1  reset; one clock, reset asynchronous and active-low.
REQ-006 scl_i  in  1  I2C clock from the bus (wired-AND).
REQ-007 sda_i  in  1  I2C data from the bus (wired-AND).
REQ-008 sda_o  out  1  open-drain data drive: 0 pulls low, 1 releases.
REQ-009 scl_o  out  1  open-drain clock drive: 0 stretches, 1 releases.
REQ-010 busy_o  out  1  high from a START to the STOP that follows it.
REQ-011 wr_stb_o  out  1  one-cycle pulse per register written.
REQ-012 wr_addr_o  out  $clog2(MEM_DEPTH)  register index of the write.
REQ-013 wr_data_o  out  8  data of the write.

Function
REQ-014 scl_i and sda_i SHALL pass through 2-flop synchronizers; all detection SHALL use the synchronized values; clk_i SHALL be at least 8x the SCL rate.
REQ-015 Condition detection:
- START: synchronized SDA falls while SCL is high.
- STOP: synchronized SDA rises while SCL is high.
REQ-016 SDA SHALL be sampled on the synchronized SCL rising edge; sda_o SHALL change only in the cycle after a synchronized SCL falling edge.
REQ-017 FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_STOP.
REQ-018 START (including repeated START) SHALL go to ADDR from any state; STOP SHALL go to IDLE from any state.
REQ-019 ADDR address match:
- The 8 bits SHALL be collected MSB first.
- On match, pull SDA low for the ACK bit.
- Then go to PTR if R/W=0; if R/W=1, go to RD with the shift register loaded from mem[ptr].
REQ-020 ADDR mismatch: SDA SHALL stay released and the FSM SHALL go to WAIT_STOP.
REQ-021 PTR:
- The first written byte after the address SHALL load ptr with its low $clog2(MEM_DEPTH) bits.
- ACK it, then go to WR.
REQ-022 WR:
- Each further byte SHALL write mem[ptr] and pulse wr_stb_o in the cycle the 8th bit is sampled.
- It SHALL then ACK and increment ptr modulo MEM_DEPTH.
REQ-023 RD, data output:
- SHALL drive mem[ptr] MSB first, then release SDA for the master's ACK bit.
- ptr SHALL increment modulo MEM_DEPTH after each byte is sent.
REQ-024 RD, master response:
- Master ACK (0): reload from mem[ptr] and continue in RD.
- Master NACK (1): go to WAIT_STOP with SDA released.
REQ-025 ptr SHALL persist across transactions, so a write of the pointer byte followed by a repeated START and read returns mem[ptr].
REQ-026 A START or STOP while sda_o is low SHALL release sda_o within one clk_i cycle.

Reset
REQ-027 While rst_ni is low, outputs SHALL hold: sda_o=1, scl_o=1, busy_o=0, wr_stb_o=0, wr_addr_o=0, wr_data_o=0.
REQ-028 While rst_ni is low, state SHALL hold: FSM=IDLE, ptr=0, all mem entries=8'h00, synchronizers=1.
REQ-029 Reset mid-transfer SHALL abort the transfer; after release the block SHALL ignore the bus until the next START.

Configuration
REQ-030 With I2C_SLAVE_CLK_STRETCH_EN defined, scl_o SHALL go low in the cycle after the SCL falling edge that ends each ACK bit (its own or the master's), stay low for STRETCH_CYCLES clk_i cycles, then release.
REQ-031 Without the macro, scl_o SHALL be constant 1 and no stretch counter SHALL be built.

Structure
REQ-032 Package i2c_slave_pkg SHALL hold:
- the FSM state enum;
- the condition enum (NONE, START, STOP);
- constants I2C_READ=1 and I2C_WRITE=0.
REQ-033 Sub-module i2c_cond_det SHALL contain the synchronizers and the edge/START/STOP detection.

Verification
REQ-034 Write 0x22/W, ptr 0x03, then 0xA5 and 0x5A:
- all 4 bytes are ACKed;
- wr_stb_o pulses with wr_addr_o=3/data 0xA5, then 4/0x5A.
REQ-035 Write 0x22/W, ptr 0x03, repeated START, 0x22/R, read 2 bytes with ACK then NACK -> returns 0xA5 then 0x5A, then SDA is released.
REQ-036 Address 0x23/W -> ACK bit reads 1, and subsequent bytes cause no wr_stb_o.
REQ-037 Write 0x22/W, ptr 0x0F, then 0x11 and 0x22 -> mem[15]=0x11, mem[0]=0x22 (wrap).
REQ-038 rst_ni low during the 4th bit of a read -> SDA released; then a fresh write 0x22/W, ptr 0x00 reads back 0x00.
REQ-039 With I2C_SLAVE_CLK_STRETCH_EN and STRETCH_CYCLES=8: SCL held low 8 clk_i cycles after each ACK, and data is intact.
